// File: rtl/bufgt_div_ctrl.sv
// -----------------------------------------------------------------------------
// bufgt_div_ctrl
//   Sequencer that safely changes the divide code of a BUFG_GT-style clock
//   buffer. A request drops CE, pulses CLR, swaps DIV while the buffer is
//   gated and held in clear, waits out the clear pipeline and re-enables CE.
//   DIV therefore never changes while CE is high, so no runt pulse escapes.
//
// Parameters
//   INIT_DIV   divide code applied at reset
//   CE_WAIT    cycles CE is held low before CLR (1..255)
//   CLR_WIDTH  cycles CLR is held high (1..255)
//   SETTLE     length of each of the HOLD and ENABLE phases (1..255)
//
// Ports
//   i_clk          single clock (same net as the buffer's I input)
//   i_rst          synchronous active-high reset
//   i_req_valid    requester presents a new divide code
//   i_req_div      requested divide code (buffer DIV encoding)
//   o_req_ready    request accepted this cycle (state is IDLE)
//   o_buf_ce       buffer CE
//   o_buf_clr      buffer CLR
//   o_buf_div      buffer DIV
//   o_buf_cemask   tied 0, CE always honoured
//   o_buf_clrmask  tied 0, CLR always honoured
//   o_busy         state is not IDLE
//   o_done         one-cycle pulse when a sequence completes
//
// Optional build macro
//   BUFGT_SKIP_SAME_DIV_EN  a request for the code already on DIV completes
//                           immediately (DONE next cycle) without gating.
// -----------------------------------------------------------------------------
module bufgt_div_ctrl #(
  parameter logic [2:0] INIT_DIV  = 3'd0,
  parameter int         CE_WAIT   = 4,
  parameter int         CLR_WIDTH = 2,
  parameter int         SETTLE    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  input  logic [2:0] i_req_div,
  output logic       o_req_ready,
  output logic       o_buf_ce,
  output logic       o_buf_clr,
  output logic [2:0] o_buf_div,
  output logic       o_buf_cemask,
  output logic       o_buf_clrmask,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [7:0] CE_WAIT_C   = 8'(CE_WAIT);
  localparam logic [7:0] CLR_WIDTH_C = 8'(CLR_WIDTH);
  localparam logic [7:0] SETTLE_C    = 8'(SETTLE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GATE   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ENABLE = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_pend;
  logic       r_buf_ce;
  logic       r_buf_clr;
  logic [2:0] r_buf_div;
  logic       r_done;

  logic       w_accept;
  logic       w_skip;
  logic       w_last;

  assign w_accept = i_req_valid & (r_state == ST_IDLE);
  // A phase ends on the cycle its counter reads 1.
  assign w_last   = (r_cnt == 8'd1);

`ifdef BUFGT_SKIP_SAME_DIV_EN
  assign w_skip = (i_req_div == r_buf_div);
`else
  assign w_skip = 1'b0;
`endif

  // Sequencer: state, phase counter, pending code and registered buffer controls.
  // Buffer outputs are assigned on the transition edge so they are valid in
  // the first cycle of the new state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_cnt     <= CLR_WIDTH_C;
      r_pend    <= INIT_DIV;
      r_buf_ce  <= 1'b0;
      r_buf_clr <= 1'b1;
      r_buf_div <= INIT_DIV;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_buf_ce  <= 1'b1;
          r_buf_clr <= 1'b0;
          if (w_accept) begin
            if (w_skip) begin
              r_done <= 1'b1;
            end else begin
              r_pend   <= i_req_div;
              r_state  <= ST_GATE;
              r_cnt    <= CE_WAIT_C;
              r_buf_ce <= 1'b0;
            end
          end
        end
        ST_GATE: begin
          if (w_last) begin
            // DIV is swapped together with the CLR rise, while CE is low.
            r_state   <= ST_CLEAR;
            r_cnt     <= CLR_WIDTH_C;
            r_buf_clr <= 1'b1;
            r_buf_div <= r_pend;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_CLEAR: begin
          if (w_last) begin
            r_state   <= ST_HOLD;
            r_cnt     <= SETTLE_C;
            r_buf_clr <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_HOLD: begin
          if (w_last) begin
            r_state  <= ST_ENABLE;
            r_cnt    <= SETTLE_C;
            r_buf_ce <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_ENABLE: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          // Illegal encoding: recover through a full clear sequence.
          r_state   <= ST_CLEAR;
          r_cnt     <= CLR_WIDTH_C;
          r_buf_ce  <= 1'b0;
          r_buf_clr <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready   = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_buf_ce      = r_buf_ce;
  assign o_buf_clr     = r_buf_clr;
  assign o_buf_div     = r_buf_div;
  assign o_done        = r_done;
  assign o_buf_cemask  = 1'b0;
  assign o_buf_clrmask = 1'b0;

endmodule

// File: tb/tb_bufgt_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bufgt_div_ctrl
//   Self-checking bench. A reference model tracks the age of the current
//   sequence (cycles since acceptance) and derives every output from the
//   phase boundaries with plain arithmetic. Directed scenarios cover reset,
//   a divide change, busy rejection, back-to-back requests, mid-sequence
//   reset and the same-code request, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_bufgt_div_ctrl;

  localparam logic [2:0] INIT_DIV  = 3'd0;
  localparam int         CW        = 4;
  localparam int         CLRW      = 2;
  localparam int         ST        = 4;
  localparam int         LAT       = 1 + CW + CLRW + 2 * ST;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_div;
  logic       o_req_ready;
  logic       o_buf_ce;
  logic       o_buf_clr;
  logic [2:0] o_buf_div;
  logic       o_buf_cemask;
  logic       o_buf_clrmask;
  logic       o_busy;
  logic       o_done;

  always #5 clk = ~clk;

  bufgt_div_ctrl #(
    .INIT_DIV  (INIT_DIV),
    .CE_WAIT   (CW),
    .CLR_WIDTH (CLRW),
    .SETTLE    (ST)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .i_req_div     (req_div),
    .o_req_ready   (o_req_ready),
    .o_buf_ce      (o_buf_ce),
    .o_buf_clr     (o_buf_clr),
    .o_buf_div     (o_buf_div),
    .o_buf_cemask  (o_buf_cemask),
    .o_buf_clrmask (o_buf_clrmask),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  logic [9:0] w_outs;
  assign w_outs = {o_req_ready, o_buf_ce, o_buf_clr, o_buf_div,
                   o_buf_cemask, o_buf_clrmask, o_busy, o_done};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: age 0 = idle, 1..LAT-1 = inside a sequence.
  int         m_age  = CW + 1;
  logic       m_done = 1'b0;
  logic [2:0] m_div  = INIT_DIV;
  logic [2:0] m_pend = INIT_DIV;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [9:0] model_outs();
    logic ce;
    logic clr;
    ce  = (m_age == 0) || (m_age > CW + CLRW + ST);
    clr = (m_age >= CW + 1) && (m_age <= CW + CLRW);
    return {(m_age == 0), ce, clr, m_div, 1'b0, 1'b0, (m_age != 0), m_done};
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    if (rst) begin
      m_age = CW + 1;          // reset behaves like the first CLEAR cycle
      m_div = INIT_DIV;
    end else if (m_age == 0) begin
      if (req_valid) begin
`ifdef BUFGT_SKIP_SAME_DIV_EN
        if (req_div == m_div) m_done = 1'b1;
        else begin
          m_age  = 1;
          m_pend = req_div;
        end
`else
        m_age  = 1;
        m_pend = req_div;
`endif
      end
    end else begin
      m_age++;
      if (m_age == CW + 1) m_div = m_pend;
      if (m_age == LAT) begin
        m_age  = 0;
        m_done = 1'b1;
      end
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("outs", 32'(w_outs), 32'(model_outs()));
  endtask

  task automatic wait_done(input int limit, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < limit && !found; i++) begin
      tick();
      n++;
      if (o_done) found = 1'b1;
    end
    check("done_timeout", 32'(found), 32'd1);
  endtask

  logic ce_h  [0:LAT];
  logic clr_h [0:LAT];
  logic [2:0] div_h [0:LAT];
  logic done_h [0:LAT];

  initial begin
    int n;
    int n2;
    rst = 1'b1; req_valid = 1'b0; req_div = 3'd0;

    // Reset held 3 cycles.
    repeat (3) tick();
    check("rst_clr", 32'(o_buf_clr), 32'd1);
    check("rst_ce", 32'(o_buf_ce), 32'd0);
    check("rst_div", 32'(o_buf_div), 32'(INIT_DIV));
    check("rst_busy", 32'(o_busy), 32'd1);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    rst = 1'b0;
    // Counted from the edge that ends the last RST-high cycle this is
    // 1+CLR_WIDTH+2*SETTLE; counted in ticks after release it is one less.
    wait_done(40, n);
    check("rst_done_lat", 32'(n), 32'(CLRW + 2 * ST));
    check("rst_ready_after", 32'(o_req_ready), 32'd1);
    check("rst_ce_after", 32'(o_buf_ce), 32'd1);

    // Divide change to 5, recorded per cycle age.
    req_valid = 1'b1; req_div = 3'd5;
    for (int a = 1; a <= LAT; a++) begin
      tick();
      req_valid = 1'b0;
      ce_h[a] = o_buf_ce; clr_h[a] = o_buf_clr; div_h[a] = o_buf_div; done_h[a] = o_done;
    end
    check("chg_ce_fall", 32'(ce_h[1]), 32'd0);
    check("chg_clr_pre", 32'(clr_h[4]), 32'd0);
    check("chg_clr_t5", 32'(clr_h[5]), 32'd1);
    check("chg_clr_t6", 32'(clr_h[6]), 32'd1);
    check("chg_clr_post", 32'(clr_h[7]), 32'd0);
    check("chg_div_pre", 32'(div_h[4]), 32'(INIT_DIV));
    check("chg_div_t5", 32'(div_h[5]), 32'd5);
    check("chg_ce_t10", 32'(ce_h[10]), 32'd0);
    check("chg_ce_rise", 32'(ce_h[11]), 32'd1);
    check("chg_done_early", 32'(done_h[14]), 32'd0);
    check("chg_done", 32'(done_h[15]), 32'd1);

    // Busy rejection: a stray request at T+3 must be ignored.
    req_valid = 1'b1; req_div = 3'd1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    req_valid = 1'b1; req_div = 3'd2;
    tick();
    req_valid = 1'b0;
    check("busy_ready", 32'(o_req_ready), 32'd0);
    wait_done(40, n);
    check("busy_div", 32'(o_buf_div), 32'd1);

    // Back-to-back: valid held through DONE.
    req_valid = 1'b1; req_div = 3'd3;
    tick();
    req_div = 3'd7;
    wait_done(40, n);
    check("b2b_first", 32'(n + 1), 32'(LAT));
    tick();
    req_valid = 1'b0;
    check("b2b_ce_fall", 32'(o_buf_ce), 32'd0);
    wait_done(40, n2);
    check("b2b_second", 32'(n2 + 1), 32'(LAT));
    check("b2b_div", 32'(o_buf_div), 32'd7);

    // Mid-sequence reset during HOLD of a change to 4.
    req_valid = 1'b1; req_div = 3'd4;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_div", 32'(o_buf_div), 32'(INIT_DIV));
    check("mid_rst_clr", 32'(o_buf_clr), 32'd1);
    wait_done(40, n);
    check("mid_rst_final_div", 32'(o_buf_div), 32'(INIT_DIV));

    // Request the code already applied.
    req_valid = 1'b1; req_div = INIT_DIV;
    tick();
    req_valid = 1'b0;
`ifdef BUFGT_SKIP_SAME_DIV_EN
    check("same_done", 32'(o_done), 32'd1);
    check("same_busy", 32'(o_busy), 32'd0);
    check("same_ce", 32'(o_buf_ce), 32'd1);
`else
    check("same_busy", 32'(o_busy), 32'd1);
    check("same_ce", 32'(o_buf_ce), 32'd0);
    wait_done(40, n);
    check("same_lat", 32'(n + 1), 32'(LAT));
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_div   = 3'($urandom);
      tick();
    end
    rst = 1'b0; req_valid = 1'b0;
    repeat (LAT + 2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
